// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: an instruction port and a data port share a single RAM port.
// Data normally wins, but an instruction request that keeps being denied eventually gains priority.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  // instruction requester
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  // data requester
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  // observation
  output logic [1:0]  gnt
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;

  logic dpend;
  logic starved;
  logic icomplete;
  logic dcomplete;

  assign dpend     = dREN | dWEN;
  assign starved   = starve_cnt >= LIMIT;
  assign icomplete = (state == IGNT) && (ramstate == RAM_ACCESS);
  assign dcomplete = (state == DGNT) && (ramstate == RAM_ACCESS);

  // BUSY, FREE and ERROR all hold the grant; ERROR simply reissues the same access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dpend && !starved) begin
            state <= DGNT;
          end else if (iREN && (!dpend || starved)) begin
            state <= IGNT;
          end
        end
        IGNT: begin
          if (icomplete || !iREN) state <= IDLE;
        end
        DGNT: begin
          if (dcomplete || !dpend) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (!iREN || icomplete) begin
        starve_cnt <= '0;
      end else if (state != IGNT && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = iREN;
    dwait    = dpend;

    unique case (state)
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (icomplete) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      DGNT: begin
        // Write takes precedence when both enables are set.
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramaddr  = daddr;
          ramstore = dstore;
        end else if (dREN) begin
          ramREN  = 1'b1;
          ramaddr = daddr;
        end
        if (dcomplete) begin
          dwait = 1'b0;
          if (!dWEN) dload = ramload;
        end
      end
      default: ;
    endcase
  end

  assign gnt = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; a scoreboard holds the expected RAM transaction for each
// completion and a negedge monitor pops and compares whenever a grant sees ACCESS.
module tb_mem_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic [1:0]  gnt;

  typedef struct {
    logic [1:0]  gnt;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   ilow  = 0;
  int   ndata;
  logic got_i;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .gnt      (gnt)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    iREN     = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    ramstate = FREE;
  endtask

  task automatic push(input logic [1:0] g, input logic [31:0] a, input logic we,
                      input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    e.gnt   = g;
    e.addr  = a;
    e.we    = we;
    e.wdata = wd;
    e.rdata = rd;
    sb.push_back(e);
  endtask

  // Completion monitor: any grant state seeing ACCESS must match the next expected transaction.
  always @(negedge CLK) begin
    if (iREN && !iwait) ilow++;
    if (gnt != 2'd0 && ramstate == ACCESS) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_completion", 32'(gnt), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("cmp_gnt", 32'(gnt), 32'(mon_e.gnt));
        check_eq("cmp_addr", ramaddr, mon_e.addr);
        check_eq("cmp_wen", 32'(ramWEN), 32'(mon_e.we));
        check_eq("cmp_store", ramstore, mon_e.wdata);
        if (mon_e.gnt == 2'd1) begin
          check_eq("cmp_iwait", 32'(iwait), 32'd0);
          check_eq("cmp_iload", iload, mon_e.rdata);
        end else begin
          check_eq("cmp_dwait", 32'(dwait), 32'd0);
          check_eq("cmp_dload", dload, mon_e.we ? 32'd0 : mon_e.rdata);
        end
      end
    end
  end

  initial begin
    CLK    = 1'b0;
    nRST   = 1'b0;
    iaddr  = '0;
    daddr  = '0;
    dstore = '0;
    ramload = '0;
    idle_inputs();

    // Reset values, with wait outputs following the requests.
    #2;
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_ramren", 32'(ramREN), 32'd0);
    check_eq("rst_ramaddr", ramaddr, 32'd0);
    iREN = 1'b1;
    dWEN = 1'b1;
    ramload = 32'hFFFF_FFFF;
    settle();
    check_eq("rst_iwait", 32'(iwait), 32'd1);
    check_eq("rst_dwait", 32'(dwait), 32'd1);
    check_eq("rst_ramwen", 32'(ramWEN), 32'd0);
    check_eq("rst_iload", iload, 32'd0);
    idle_inputs();
    step();
    step();
    nRST = 1'b1;
    step();

    // Single instruction fetch, ACCESS on the second cycle after the grant.
    ilow    = 0;
    iREN    = 1'b1;
    iaddr   = 32'h40;
    ramload = 32'h00A0_0093;
    settle();
    check_eq("i_idle_gnt", 32'(gnt), 32'd0);
    step();
    check_eq("i_gnt", 32'(gnt), 32'd1);
    check_eq("i_ramren", 32'(ramREN), 32'd1);
    check_eq("i_ramaddr", ramaddr, 32'h40);
    check_eq("i_load_early", iload, 32'd0);
    ramstate = BUSY;
    step();
    check_eq("i_busy_iwait", 32'(iwait), 32'd1);
    push(2'd1, 32'h40, 1'b0, 32'd0, 32'h00A0_0093);
    ramstate = ACCESS;
    step();
    idle_inputs();
    settle();
    check_eq("i_after_gnt", 32'(gnt), 32'd0);
    check_eq("i_after_load", iload, 32'd0);
    check_eq("i_iwait_low_cycles", 32'(ilow), 32'd1);
    step();

    // Simultaneous requests: data first, instruction after the bubble.
    iREN  = 1'b1;
    dREN  = 1'b1;
    iaddr = 32'h44;
    daddr = 32'h100;
    step();
    check_eq("both_first_gnt", 32'(gnt), 32'd2);
    check_eq("both_iwait", 32'(iwait), 32'd1);
    push(2'd2, 32'h100, 1'b0, 32'd0, 32'h1111);
    ramload  = 32'h1111;
    ramstate = ACCESS;
    step();
    dREN     = 1'b0;
    ramstate = FREE;
    settle();
    check_eq("both_bubble", 32'(gnt), 32'd0);
    step();
    check_eq("both_second_gnt", 32'(gnt), 32'd1);
    check_eq("both_i_addr", ramaddr, 32'h44);
    push(2'd1, 32'h44, 1'b0, 32'd0, 32'h2222);
    ramload  = 32'h2222;
    ramstate = ACCESS;
    step();
    idle_inputs();
    step();

    // Starvation: continuous data traffic, instruction must win after the limit.
    iREN     = 1'b1;
    dREN     = 1'b1;
    iaddr    = 32'h48;
    daddr    = 32'h200;
    ndata    = 0;
    got_i    = 1'b0;
    for (int k = 0; k < 12 && !got_i; k++) begin
      step();
      if (gnt == 2'd2) begin
        ndata++;
        ramload = 32'h5000 + 32'(ndata);
        push(2'd2, 32'h200, 1'b0, 32'd0, ramload);
        ramstate = ACCESS;
      end else if (gnt == 2'd1) begin
        got_i = 1'b1;
      end else begin
        ramstate = FREE;
      end
    end
    check_eq("starve_igrant", 32'(got_i), 32'd1);
    check_eq("starve_data_grants", 32'(ndata), 32'd2);
    check_eq("starve_dwait", 32'(dwait), 32'd1);
    push(2'd1, 32'h48, 1'b0, 32'd0, 32'h6000);
    ramload  = 32'h6000;
    ramstate = ACCESS;
    step();
    idle_inputs();
    step();

    // Write wins over read; outputs held while BUSY.
    dREN   = 1'b1;
    dWEN   = 1'b1;
    daddr  = 32'h80;
    dstore = 32'hDEAD_BEEF;
    step();
    ramstate = BUSY;
    for (int k = 0; k < 2; k++) begin
      settle();
      check_eq("wr_ramwen", 32'(ramWEN), 32'd1);
      check_eq("wr_ramren", 32'(ramREN), 32'd0);
      check_eq("wr_ramaddr", ramaddr, 32'h80);
      check_eq("wr_ramstore", ramstore, 32'hDEAD_BEEF);
      check_eq("wr_dwait", 32'(dwait), 32'd1);
      step();
    end
    push(2'd2, 32'h80, 1'b1, 32'hDEAD_BEEF, 32'd0);
    ramload  = 32'h7777;
    ramstate = ACCESS;
    step();
    idle_inputs();
    settle();
    check_eq("wr_done_gnt", 32'(gnt), 32'd0);
    step();

    // ERROR holds the grant with dwait high, then one completion.
    dREN  = 1'b1;
    daddr = 32'h90;
    step();
    ramstate = ERROR;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_eq("err_gnt", 32'(gnt), 32'd2);
      check_eq("err_dwait", 32'(dwait), 32'd1);
      check_eq("err_ramren", 32'(ramREN), 32'd1);
      check_eq("err_dload", dload, 32'd0);
      step();
    end
    push(2'd2, 32'h90, 1'b0, 32'd0, 32'h3333);
    ramload  = 32'h3333;
    ramstate = ACCESS;
    step();
    dREN     = 1'b0;
    ramstate = FREE;
    settle();
    check_eq("err_done_gnt", 32'(gnt), 32'd0);
    step();

    // Abort: instruction request dropped while the RAM is busy.
    iREN  = 1'b1;
    iaddr = 32'h4C;
    step();
    check_eq("abort_gnt", 32'(gnt), 32'd1);
    ramstate = BUSY;
    iREN     = 1'b0;
    step();
    check_eq("abort_idle", 32'(gnt), 32'd0);
    check_eq("abort_ramren", 32'(ramREN), 32'd0);
    idle_inputs();
    step();

    // Reset during a data grant.
    dREN  = 1'b1;
    daddr = 32'hA0;
    step();
    check_eq("rg_gnt", 32'(gnt), 32'd2);
    ramstate = BUSY;
    settle();
    nRST = 1'b0;
    settle();
    check_eq("rg_rst_gnt", 32'(gnt), 32'd0);
    check_eq("rg_rst_ramren", 32'(ramREN), 32'd0);
    check_eq("rg_rst_ramwen", 32'(ramWEN), 32'd0);
    check_eq("rg_rst_ramaddr", ramaddr, 32'd0);
    check_eq("rg_rst_dwait", 32'(dwait), 32'd1);
    ramstate = ACCESS;
    step();
    check_eq("rg_held_gnt", 32'(gnt), 32'd0);
    check_eq("rg_held_dload", dload, 32'd0);
    nRST     = 1'b1;
    ramstate = FREE;
    settle();
    check_eq("rg_release_ramren", 32'(ramREN), 32'd0);
    step();
    check_eq("rg_resume_gnt", 32'(gnt), 32'd2);
    push(2'd2, 32'hA0, 1'b0, 32'd0, 32'h4444);
    ramload  = 32'h4444;
    ramstate = ACCESS;
    step();
    idle_inputs();
    step();

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
